// File: rtl/int_timer_ctrl.sv
// Interrupt entry/return controller with a reloadable down-counting timer and an
// edge-detected external request; drives the save/restore pulses for the PC register.
module int_timer_ctrl #(
  parameter int unsigned           PERIOD_W   = 32,
  parameter logic [PERIOD_W-1:0]   PERIOD_RST = 32'd1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                timer_load,
  input  logic [PERIOD_W-1:0] timer_period,
  input  logic                int_en,
  input  logic                ext_irq,
  input  logic                eret,
  input  logic                pipe_stall,
  output logic                INT_detected,
  output logic                INT_restore,
  output logic                in_isr,
  output logic [1:0]          int_cause,
  output logic [PERIOD_W-1:0] timer_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    ISR    = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] period;
  logic                timer_pending;
  logic                ext_pending;
  logic                ext_prev;
  logic                timer_expire;
  logic                ext_rise;
  logic                entering;

  // A load in the same cycle as expiry replaces the reload and suppresses the event.
  assign timer_expire = !timer_load && (period != '0) && (timer_count == PERIOD_W'(1));
  assign ext_rise     = ext_irq && !ext_prev;
  assign entering     = (state == ENTER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period      <= PERIOD_RST;
      timer_count <= PERIOD_RST;
    end else if (timer_load) begin
      period      <= timer_period;
      timer_count <= timer_period;
    end else if (period != '0) begin
      timer_count <= (timer_count == PERIOD_W'(1)) ? period : timer_count - PERIOD_W'(1);
    end
  end

  // Set wins over the clear at entry so an event arriving that cycle survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_pending <= 1'b0;
      ext_pending   <= 1'b0;
      ext_prev      <= 1'b0;
      int_cause     <= 2'b00;
    end else begin
      ext_prev      <= ext_irq;
      timer_pending <= timer_expire | (timer_pending & ~entering);
      ext_pending   <= ext_rise | (ext_pending & ~entering);
      if (entering) begin
        int_cause <= {ext_pending, timer_pending};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (int_en && (timer_pending || ext_pending) && !pipe_stall) begin
          state_next = ENTER;
        end
      end
      ENTER:  state_next = ISR;
      ISR: begin
        if (eret) begin
          state_next = RETURN;
        end
      end
      RETURN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign INT_detected = (state == ENTER);
  assign INT_restore  = (state == RETURN);
  assign in_isr       = (state == ISR) || (state == RETURN);

endmodule

// File: tb/tb_int_timer_ctrl.sv
// Directed bench for int_timer_ctrl: timer entry, coincident causes, stall deferral,
// no nesting, zero-period load at expiry and reset during the handler.
module tb_int_timer_ctrl;

  logic        clk;
  logic        reset;
  logic        timer_load;
  logic [31:0] timer_period;
  logic        int_en;
  logic        ext_irq;
  logic        eret;
  logic        pipe_stall;
  logic        INT_detected;
  logic        INT_restore;
  logic        in_isr;
  logic [1:0]  int_cause;
  logic [31:0] timer_count;

  int checks   = 0;
  int failures = 0;

  int_timer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .timer_load   (timer_load),
    .timer_period (timer_period),
    .int_en       (int_en),
    .ext_irq      (ext_irq),
    .eret         (eret),
    .pipe_stall   (pipe_stall),
    .INT_detected (INT_detected),
    .INT_restore  (INT_restore),
    .in_isr       (in_isr),
    .int_cause    (int_cause),
    .timer_count  (timer_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (!reset && (INT_detected || INT_restore)) begin
      check("pulse_exclusive", {31'd0, INT_detected & INT_restore}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1; timer_load = 1'b0; timer_period = 32'd0; int_en = 1'b0;
    ext_irq = 1'b0; eret = 1'b0; pipe_stall = 1'b0;
    steps(2);
    check("rst_detected", {31'd0, INT_detected}, 32'd0);
    check("rst_restore",  {31'd0, INT_restore},  32'd0);
    check("rst_in_isr",   {31'd0, in_isr},       32'd0);
    check("rst_cause",    {30'd0, int_cause},    32'd0);
    check("rst_count",    timer_count,           32'd1000);
    reset = 1'b0;
    step();
    check("first_decrement", timer_count, 32'd999);

    // timer entry with period 5
    timer_load = 1'b1; timer_period = 32'd5; int_en = 1'b1;
    step();
    timer_load = 1'b0;
    check("load_count", timer_count, 32'd5);
    steps(4);
    check("count_at_one", timer_count, 32'd1);
    step();
    check("reload_count", timer_count, 32'd5);
    check("no_detect_at_expiry", {31'd0, INT_detected}, 32'd0);
    step();
    check("timer_detect", {31'd0, INT_detected}, 32'd1);
    step();
    check("timer_detect_one_cycle", {31'd0, INT_detected}, 32'd0);
    check("timer_in_isr", {31'd0, in_isr}, 32'd1);
    check("timer_cause", {30'd0, int_cause}, 32'd1);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("timer_restore", {31'd0, INT_restore}, 32'd1);
    check("return_in_isr", {31'd0, in_isr}, 32'd1);
    check("return_count", timer_count, 32'd2);

    // ext edge coincides with the next timer expiry
    step();
    check("idle_after_return", {31'd0, INT_restore | in_isr}, 32'd0);
    check("count_before_coincide", timer_count, 32'd1);
    ext_irq = 1'b1;
    step();
    check("coincide_no_detect", {31'd0, INT_detected}, 32'd0);
    step();
    check("coincide_detect", {31'd0, INT_detected}, 32'd1);
    step();
    check("coincide_cause", {30'd0, int_cause}, 32'd3);
    check("coincide_single_entry", {31'd0, INT_detected}, 32'd0);

    // no nesting: edge during the handler waits for return
    ext_irq = 1'b0; timer_load = 1'b1; timer_period = 32'd100;
    step();
    timer_load = 1'b0;
    ext_irq = 1'b1;
    step();
    check("nest_no_detect_a", {31'd0, INT_detected}, 32'd0);
    step();
    check("nest_no_detect_b", {31'd0, INT_detected}, 32'd0);
    check("nest_still_isr", {31'd0, in_isr}, 32'd1);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("nest_restore", {31'd0, INT_restore}, 32'd1);
    step();
    check("nest_idle_gap", {31'd0, INT_detected | INT_restore | in_isr}, 32'd0);
    check("cause_held", {30'd0, int_cause}, 32'd3);
    step();
    check("nest_detect", {31'd0, INT_detected}, 32'd1);
    step();
    check("nest_cause", {30'd0, int_cause}, 32'd2);
    eret = 1'b1;
    step();
    eret = 1'b0;
    steps(2);
    check("level_no_retrigger_a", {31'd0, INT_detected}, 32'd0);
    step();
    check("level_no_retrigger_b", {31'd0, INT_detected}, 32'd0);
    check("count_runs_through", timer_count, 32'd90);

    // stall defers entry
    pipe_stall = 1'b1; ext_irq = 1'b0;
    step();
    ext_irq = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_detect", {31'd0, INT_detected}, 32'd0);
    end
    pipe_stall = 1'b0;
    step();
    check("stall_release_detect", {31'd0, INT_detected}, 32'd1);
    step();
    check("stall_cause", {30'd0, int_cause}, 32'd2);
    eret = 1'b1;
    step();
    eret = 1'b0;
    ext_irq = 1'b0;
    step();
    check("stall_back_idle", {31'd0, in_isr}, 32'd0);

    // load of zero period exactly at expiry
    int_en = 1'b0; timer_load = 1'b1; timer_period = 32'd3;
    step();
    timer_load = 1'b0;
    steps(2);
    check("zero_pre_count", timer_count, 32'd1);
    timer_load = 1'b1; timer_period = 32'd0;
    step();
    timer_load = 1'b0; int_en = 1'b1;
    check("zero_count", timer_count, 32'd0);
    steps(2);
    check("zero_no_entry", {31'd0, INT_detected}, 32'd0);
    check("zero_frozen", timer_count, 32'd0);

    // reset while the handler runs
    timer_load = 1'b1; timer_period = 32'd2;
    step();
    timer_load = 1'b0;
    steps(4);
    check("pre_reset_in_isr", {31'd0, in_isr}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_in_isr", {31'd0, in_isr}, 32'd0);
    check("async_rst_count", timer_count, 32'd1000);
    check("async_rst_cause", {30'd0, int_cause}, 32'd0);
    step();
    check("rst_no_restore", {31'd0, INT_restore}, 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_no_restore", {31'd0, INT_restore | INT_detected | in_isr}, 32'd0);
    check("post_rst_count", timer_count, 32'd999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_timer_ctrl.md
INT_TIMER_CTRL -- requirements
Module: int_timer_ctrl

Interface
REQ-001 Parameter: PERIOD_RST, default 32'd1000; timer reload period after reset.
REQ-002 Parameter: PERIOD_W, default 32; timer counter width.
REQ-003 The block SHALL use clock clk and reset reset, asynchronous, active-high.
REQ-004 Ports SHALL be exactly as follows:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous active-high reset.
- timer_load  in  1  load timer_period into period register and counter.
- timer_period  in  PERIOD_W  new timer period; value 0 disables the timer.
- int_en  in  1  global interrupt enable.
- ext_irq  in  1  external interrupt request, level input, synchronous to clk.
- eret  in  1  ISR-return instruction decoded; one-cycle pulse.
- pipe_stall  in  1  pipeline stalled by hazard; interrupt entry deferred while high.
- INT_detected  out  1  one-cycle pulse; PC register saves PC and jumps to handler.
- INT_restore  out  1  one-cycle pulse; PC register restores saved PC.
- in_isr  out  1  handler executing.
- int_cause  out  2  cause latched at entry: bit0 timer, bit1 external.
- timer_count  out  PERIOD_W  current down-counter value.

Function
REQ-005 Timer SHALL decrement timer_count by 1 per cycle while period != 0; when timer_count == 1, the next edge SHALL load period and set timer_pending.
REQ-006 When period == 0, the counter SHALL hold and never set timer_pending.
REQ-007 timer_load SHALL win over decrement and expiry in the same cycle: period and count <= timer_period, and timer_pending is not set that cycle.
REQ-008 A registered rising-edge detector on ext_irq SHALL set ext_pending (prev 0 -> cur 1); a level held high SHALL set it only once.
REQ-009 Pending bits SHALL be sticky until consumed at entry; a new event on an already-set bit SHALL not count.
REQ-010 FSM states SHALL be IDLE, ENTER, ISR, RETURN, encoded in a registered state variable.
REQ-011 IDLE -> ENTER when int_en=1, (timer_pending|ext_pending)=1 and pipe_stall=0; otherwise stay in IDLE.
REQ-012 In ENTER, INT_detected=1 for exactly one cycle; int_cause <= {ext_pending, timer_pending}; both bits cleared; next state ISR.
REQ-013 A pending bit set in the same cycle as ENTER's clear SHALL remain set, so the new event is not lost.
REQ-014 In ISR, in_isr=1; eret=1 -> RETURN; new events latch as pending but do not trigger entry (no nesting).
REQ-015 In RETURN, INT_restore=1 for exactly one cycle; in_isr=1; next state IDLE.
REQ-016 eret SHALL be ignored in IDLE, ENTER and RETURN.
REQ-017 INT_detected and INT_restore SHALL never both be 1 in one cycle; each SHALL be decoded only from the registered state.
REQ-018 After RETURN, at least one IDLE cycle SHALL precede the next ENTER.
REQ-019 int_cause SHALL hold its value until the next ENTER.
REQ-020 The timer SHALL keep running in all FSM states.
REQ-021 Deasserting int_en SHALL not abort ENTER, ISR or RETURN; it SHALL only block IDLE -> ENTER.

Reset
REQ-022 On reset, the block SHALL apply: state=IDLE; INT_detected=0; INT_restore=0; in_isr=0; int_cause=2'b00; pending bits=0; ext_irq edge register=0; period=PERIOD_RST; timer_count=PERIOD_RST.
REQ-023 A reset asserted mid-ISR SHALL drop to IDLE immediately with no INT_restore pulse.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Timer: load period 5, int_en=1 -> timer_pending after 5 cycles; INT_detected one cycle later, int_cause=2'b01; timer_count reloaded to 5.
- Simultaneous events: ext_irq rises in the same cycle the timer expires -> single entry with int_cause=2'b11.
- Stall: pending with pipe_stall=1 for 3 cycles -> no INT_detected until the cycle after stall drops.
- No nesting: ext edge during ISR, then eret -> INT_restore pulse, one IDLE cycle, then INT_detected with int_cause=2'b10.
- Load and zero period: timer_load at expiry with timer_period=0 -> no pending, count frozen at 0.
- Reset mid-ISR -> all outputs 0, timer_count=1000, no INT_restore pulse.
